// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request bundle: N requesters, each with valid/ready, a destination
// index and write data packed side by side.
interface regfile_wb_arbiter_if #(
  parameter int N    = 3,
  parameter int XLEN = 32
);
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [5*N-1:0]    req_rd;
  logic [XLEN*N-1:0] req_data;

  modport master (output req_valid, output req_rd, output req_data, input req_ready);
  modport slave  (input req_valid, input req_rd, input req_data, output req_ready);
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Register file write-port owner: clears x1..x31 after reset or on demand, then
// shares the single write port between N writeback sources round-robin.
module regfile_wb_arbiter #(
  parameter int N    = 3,
  parameter int XLEN = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  regfile_wb_arbiter_if.slave  req,
  input  logic                 clear_start,
  output logic                 clear_busy,
  output logic                 wr,
  output logic [4:0]           rd,
  output logic [XLEN-1:0]      rd_d
);
  localparam int PW = $clog2(N);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t          state_reg, state_next;
  logic [4:0]      idx_reg, idx_next;
  logic [PW-1:0]   ptr_reg, ptr_next;
  logic            wr_next;
  logic [4:0]      rd_next;
  logic [XLEN-1:0] rd_d_next;

  logic [PW-1:0]   cand [N];
  logic [PW-1:0]   win;
  logic            found;
  logic            accept;
  logic [4:0]      win_rd;
  logic [XLEN-1:0] win_data;

  // cand[k] is the requester k places after the pointer, wrapped modulo N
  for (genvar gi = 0; gi < N; gi++) begin : g_cand
    logic [PW:0] sum;
    logic [PW:0] sum_wrap;
    assign sum      = {1'b0, ptr_reg} + (PW+1)'(gi);
    assign sum_wrap = sum - (PW+1)'(N);
    assign cand[gi] = (sum >= (PW+1)'(N)) ? sum_wrap[PW-1:0] : sum[PW-1:0];
  end

  // Scan from the far end so the candidate closest to the pointer wins
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req.req_valid[cand[k]]) begin
        found = 1'b1;
        win   = cand[k];
      end
    end
  end

  assign accept   = (state_reg == RUN) && !clear_start && found;
  assign win_rd   = req.req_rd[5*win +: 5];
  assign win_data = req.req_data[XLEN*win +: XLEN];

  for (genvar gi = 0; gi < N; gi++) begin : g_ready
    assign req.req_ready[gi] = accept && (int'(win) == gi);
  end

  assign clear_busy = (state_reg == CLEAR);

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    ptr_next   = ptr_reg;
    wr_next    = 1'b0;
    rd_next    = rd;
    rd_d_next  = rd_d;
    case (state_reg)
      CLEAR: begin
        wr_next   = 1'b1;
        rd_next   = idx_reg;
        rd_d_next = '0;
        if (idx_reg == 5'd31) begin
          state_next = RUN;
          idx_next   = 5'd1;
        end else begin
          idx_next = idx_reg + 5'd1;
        end
      end
      RUN: begin
        if (clear_start) begin
          state_next = CLEAR;
          idx_next   = 5'd1;
        end else if (accept) begin
          // x0 writes are consumed but never reach the register file
          wr_next   = (win_rd != 5'd0);
          rd_next   = win_rd;
          rd_d_next = win_data;
          ptr_next  = (int'(win) == N - 1) ? '0 : win + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= CLEAR;
      idx_reg   <= 5'd1;
      ptr_reg   <= '0;
      wr        <= 1'b0;
      rd        <= 5'd0;
      rd_d      <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      ptr_reg   <= ptr_next;
      wr        <= wr_next;
      rd        <= rd_next;
      rd_d      <= rd_d_next;
    end
  end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized bench for regfile_wb_arbiter: a behavioural model predicts grants,
// write-port values and register file contents.
module tb_regfile_wb_arbiter;
  localparam int N    = 3;
  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            clear_start;
  logic            clear_busy;
  logic            wr;
  logic [4:0]      rd;
  logic [XLEN-1:0] rd_d;

  always #5 clk = ~clk;

  regfile_wb_arbiter_if #(.N(N), .XLEN(XLEN)) bus ();

  regfile_wb_arbiter #(.N(N), .XLEN(XLEN)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (bus),
    .clear_start (clear_start),
    .clear_busy  (clear_busy),
    .wr          (wr),
    .rd          (rd),
    .rd_d        (rd_d)
  );

  // Register file fed by the write port; starts with garbage so the clear matters
  logic [XLEN-1:0] rf [32];
  initial for (int i = 0; i < 32; i++) rf[i] <= $urandom;
  always @(posedge clk) if (wr && rd != 5'd0) rf[rd] <= rd_d;

  function automatic logic [XLEN-1:0] rf_read(input int a);
    return (a == 0) ? '0 : rf[a];
  endfunction

  int checks = 0;
  int passes = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", tag, act, exp);
  endtask

  // Reference model state
  bit              m_clear;
  int              m_idx;
  int              m_ptr;
  logic            m_wr;
  logic [4:0]      m_rd;
  logic [XLEN-1:0] m_d;
  logic [XLEN-1:0] rf_exp [32];
  int              last_grant;
  logic [4:0]      t_rd   [N];
  logic [XLEN-1:0] t_data [N];

  task automatic model_reset();
    m_clear = 1'b1; m_idx = 1; m_ptr = 0;
    m_wr = 1'b0; m_rd = '0; m_d = '0;
  endtask

  // Called at posedge+1: drive, check combinational outputs, predict, cross the edge, check registers
  task automatic cycle(input logic [N-1:0] v, input logic cs);
    logic [N-1:0] exp_ready;
    int w;
    for (int i = 0; i < N; i++) begin
      bus.req_rd[5*i +: 5]         = t_rd[i];
      bus.req_data[XLEN*i +: XLEN] = t_data[i];
    end
    bus.req_valid = v;
    clear_start   = cs;
    #3;
    w = -1;
    if (!m_clear && !cs)
      for (int k = 0; k < N; k++)
        if (w < 0 && v[(m_ptr + k) % N]) w = (m_ptr + k) % N;
    exp_ready = '0;
    if (w >= 0) exp_ready[w] = 1'b1;
    check_eq("req_ready", 32'(bus.req_ready), 32'(exp_ready));
    check_eq("clear_busy", 32'(clear_busy), 32'(m_clear));
    last_grant = w;
    if (m_clear) begin
      m_wr = 1'b1; m_rd = 5'(m_idx); m_d = '0; rf_exp[m_idx] = '0;
      if (m_idx == 31) begin m_clear = 1'b0; m_idx = 1; end
      else m_idx++;
    end else if (cs) begin
      m_clear = 1'b1; m_idx = 1; m_wr = 1'b0;
    end else if (w >= 0) begin
      m_rd = t_rd[w]; m_d = t_data[w]; m_wr = (t_rd[w] != 5'd0);
      if (m_wr) rf_exp[m_rd] = m_d;
      m_ptr = (w + 1) % N;
    end else begin
      m_wr = 1'b0;
    end
    @(posedge clk);
    #1;
    check_eq("wr", 32'(wr), 32'(m_wr));
    check_eq("rd", 32'(rd), 32'(m_rd));
    check_eq("rd_d", rd_d, m_d);
  endtask

  int grants [6];
  int lat;
  logic [N-1:0] vr;

  initial begin
    for (int i = 0; i < N; i++) begin t_rd[i] = '0; t_data[i] = '0; end
    bus.req_valid = '1;
    bus.req_rd    = '0;
    bus.req_data  = '0;
    clear_start   = 1'b0;
    model_reset();
    last_grant = -1;

    // Reset state while requests are pending
    #12;
    check_eq("rst_wr", 32'(wr), 32'd0);
    check_eq("rst_rd", 32'(rd), 32'd0);
    check_eq("rst_rd_d", rd_d, 32'd0);
    check_eq("rst_busy", 32'(clear_busy), 32'd1);
    check_eq("rst_ready", 32'(bus.req_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    // Power-up clear
    repeat (31) cycle('0, 1'b0);
    repeat (3) cycle('0, 1'b0);
    for (int i = 1; i < 32; i++) check_eq("clear_rf", rf_read(i), 32'd0);

    // Single write from requester 1
    t_rd[1] = 5'd5; t_data[1] = 32'hDEADBEEF;
    cycle(3'b010, 1'b0);
    check_eq("single_grant", 32'(last_grant), 32'd1);
    cycle('0, 1'b0);
    check_eq("x5", rf_read(5), 32'hDEADBEEF);

    // Write to x0 is consumed and dropped
    t_rd[2] = 5'd0; t_data[2] = 32'h1234;
    cycle(3'b100, 1'b0);
    check_eq("x0_grant", 32'(last_grant), 32'd2);
    check_eq("x0_wr", 32'(wr), 32'd0);
    cycle('0, 1'b0);

    // Round-robin with everyone valid, pointer now at 0
    for (int i = 0; i < N; i++) begin t_rd[i] = 5'(10 + i); t_data[i] = $urandom; end
    for (int k = 0; k < 6; k++) begin
      cycle(3'b111, 1'b0);
      grants[k] = last_grant;
    end
    for (int k = 0; k < 6; k++) check_eq("rr_grant", 32'(grants[k]), 32'(k % 3));
    cycle('0, 1'b0);

    // Re-clear with requester 0 waiting
    t_rd[0] = 5'd7; t_data[0] = 32'h55;
    cycle(3'b001, 1'b0);
    cycle('0, 1'b0);
    check_eq("x7_written", rf_read(7), 32'h55);
    cycle(3'b001, 1'b1);
    check_eq("reclear_block", 32'(last_grant), 32'hFFFFFFFF);
    lat = -1;
    for (int i = 0; i < 40; i++) begin
      cycle(3'b001, 1'b0);
      if (last_grant == 0) begin
        lat = i;
        check_eq("x7_cleared", rf_read(7), 32'd0);
        break;
      end
    end
    check_eq("reclear_latency", 32'(lat), 32'd31);
    cycle('0, 1'b0);

    // Asynchronous reset in the middle of a clear
    cycle('0, 1'b1);
    for (int i = 0; i < 40; i++) begin
      if (m_wr && m_rd == 5'd10) break;
      cycle('0, 1'b0);
    end
    check_eq("reach_rd10", 32'(rd), 32'd10);
    bus.req_valid = '1;
    #2 rst = 1'b0;
    #1;
    check_eq("arst_wr", 32'(wr), 32'd0);
    check_eq("arst_ready", 32'(bus.req_ready), 32'd0);
    check_eq("arst_busy", 32'(clear_busy), 32'd1);
    @(posedge clk); @(posedge clk); #1;
    check_eq("arst_rd", 32'(rd), 32'd0);
    rst = 1'b1;
    model_reset();
    cycle('0, 1'b0);
    check_eq("restart_rd", 32'(rd), 32'd1);
    repeat (32) cycle('0, 1'b0);

    // Random traffic; requesters hold their payload until granted
    vr = '0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!(vr[i] && last_grant != i)) begin
          vr[i]     = ($urandom_range(0, 3) != 0);
          t_rd[i]   = 5'($urandom_range(0, 31));
          t_data[i] = $urandom;
        end
      end
      cycle(vr, ($urandom_range(0, 59) == 0));
    end
    repeat (36) cycle('0, 1'b0);
    for (int i = 1; i < 32; i++) check_eq("final_rf", rf_read(i), rf_exp[i]);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
